mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Main control FSM of the multicycle processor. Sequences fetch/decode/execute/memory/writeback for each instruction.
- Drives the 4-bit ALU operation code plus all datapath enables and mux selects.
- Sits directly upstream of the ALU. It reads opcode/funct from the instruction register and stalls on a memory ready handshake.

Parameters:
- OP_W, 6, opcode field width
- FN_W, 6, funct field width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  IR[31:26], stable from DECODE onward
- funct  in  FN_W  IR[5:0], R-type function
- mem_ready  in  1  memory completes the current access this cycle
- alu_ctrl  out  4  ALU op: AND 0001, ADD 0010, SUB 0011, CMP 0100, BEQ 0101, SLL 1100, SLR 1101, SLLV 1110, SLRV 1111
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- ir_write  out  1  IR load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  0=PC address, 1=ALUOut address
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- flags_write  out  1  latch ALU zero/negative/carry/overflow into status register
- illegal  out  1  one-cycle pulse on unknown opcode/funct
- halted  out  1  high while in HALT

Behaviour:
- Reset: on rst_n low, state=INIT immediately. All outputs are 0, alu_ctrl=0000. INIT lasts exactly one cycle after release, then goes to FETCH.
- Outputs are decoded from state (Moore), except ir_write and pc_write in FETCH, which are qualified by mem_ready (Mealy). Outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00.
  - While mem_ready=0, stay and keep ir_write=pc_write=0.
  - When mem_ready=1, ir_write=pc_write=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 R-type → EXEC_R
  - 001000 ADDI or 001100 ANDI → EXEC_I
  - 100011 LW or 101011 SW → MEM_ADDR
  - 000100 BEQ → BRANCH
  - 000010 J → JUMP
  - 111111 → HALT
  - anything else: illegal=1 for this cycle, then FETCH
- EXEC_R: alu_src_a=1, alu_src_b=00. funct→alu_ctrl:
  - 100100 AND, 100000 ADD, 100010 SUB, 101010 CMP, 000000 SLL, 000010 SLR, 000100 SLLV, 000110 SLRV
  - flags_write=1 for ADD, SUB, CMP
  - CMP → FETCH (no writeback); other legal funct → WB_R
  - unknown funct: illegal=1, alu_ctrl=0000, → FETCH
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD (ADDI, flags_write=1) or AND (ANDI) → WB_I.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH. WB_I: same but reg_dst=0.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then → MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then → FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=BEQ, pc_source=01, pc_write_cond=1 → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- HALT: halted=1, all other outputs 0. Stays until reset.
- Cycle counts with mem_ready held 1: R-type 4 (CMP 3), I-type 4, LW 5, SW 4, BEQ 3, J 3, illegal 2.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- Reset asserted mid-instruction aborts it: no further write enables, return to INIT.
- State encoding is implementation choice; unreachable encodings go to INIT.

Test Plan:
- Reset release, mem_ready=1 → INIT 1 cycle with all outputs 0. Next cycle FETCH: mem_read=1, alu_ctrl=0010, ir_write=pc_write=1.
- R-type funct 100010 (SUB) → DECODE, then EXEC_R with alu_ctrl=0011 and flags_write=1, then WB_R with reg_write=1, reg_dst=1. Back in FETCH on the 5th cycle.
- LW with mem_ready=0 for 3 cycles in MEM_RD → mem_read/i_or_d held 3 cycles, no state change. After mem_ready=1, MEM_WB has reg_write=1, mem_to_reg=1.
- BEQ → BRANCH with alu_ctrl=0101, pc_source=01, pc_write_cond=1; back in FETCH the next cycle. J → pc_source=10, pc_write=1.
- opcode 010101 → illegal pulses for exactly 1 cycle in DECODE, then FETCH. R-type funct 111111 → illegal in EXEC_R, reg_write never asserted.
- opcode 111111 → halted=1 held over 20 cycles with all enables 0. rst_n low mid-MEM_WR → mem_write drops the same cycle (async), then INIT.

Source files
------------

// File: rtl/mc_main_control.sv
// Main control FSM of the multicycle processor: sequences fetch, decode,
// execute, memory and writeback, and drives ALU op, datapath enables and
// mux selects. Outputs are decoded from the current state; ir_write and
// pc_write in FETCH are additionally qualified by mem_ready.
module mc_main_control #(
  parameter int unsigned OP_W = 6,
  parameter int unsigned FN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            mem_ready,
  output logic [3:0]      alu_ctrl,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            i_or_d,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            flags_write,
  output logic            illegal,
  output logic            halted
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

  localparam logic [FN_W-1:0] FN_AND  = FN_W'(6'b100100);
  localparam logic [FN_W-1:0] FN_ADD  = FN_W'(6'b100000);
  localparam logic [FN_W-1:0] FN_SUB  = FN_W'(6'b100010);
  localparam logic [FN_W-1:0] FN_CMP  = FN_W'(6'b101010);
  localparam logic [FN_W-1:0] FN_SLL  = FN_W'(6'b000000);
  localparam logic [FN_W-1:0] FN_SLR  = FN_W'(6'b000010);
  localparam logic [FN_W-1:0] FN_SLLV = FN_W'(6'b000100);
  localparam logic [FN_W-1:0] FN_SLRV = FN_W'(6'b000110);

  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_CMP  = 4'b0100;
  localparam logic [3:0] ALU_BEQ  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SLR  = 4'b1101;
  localparam logic [3:0] ALU_SLLV = 4'b1110;
  localparam logic [3:0] ALU_SLRV = 4'b1111;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t state_q, state_d;

  // State register; reset forces INIT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = S_INIT;
    alu_ctrl      = 4'b0000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    flags_write   = 1'b0;
    illegal       = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_HALT:         state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        state_d   = S_WB_R;
        case (funct)
          FN_AND:  alu_ctrl = ALU_AND;
          FN_ADD:  begin alu_ctrl = ALU_ADD; flags_write = 1'b1; end
          FN_SUB:  begin alu_ctrl = ALU_SUB; flags_write = 1'b1; end
          FN_CMP:  begin alu_ctrl = ALU_CMP; flags_write = 1'b1; state_d = S_FETCH; end
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SLR:  alu_ctrl = ALU_SLR;
          FN_SLLV: alu_ctrl = ALU_SLLV;
          FN_SLRV: alu_ctrl = ALU_SLRV;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ADDI) begin
          alu_ctrl    = ALU_ADD;
          flags_write = 1'b1;
        end else begin
          alu_ctrl    = ALU_AND;
        end
        state_d = S_WB_I;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_BEQ;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: the stimulus process walks each
// instruction through its architectural phases, pushing the expected output
// vector for every cycle; a negedge monitor pops and compares.
module tb_mc_main_control;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       flags_write;
    logic       illegal;
    logic       halted;
  } outv_t;

  typedef enum int {
    PH_RESET, PH_INIT, PH_FETCH, PH_DECODE, PH_EXEC_R, PH_EXEC_I, PH_WB_R,
    PH_WB_I, PH_MEM_ADDR, PH_MEM_RD, PH_MEM_WR, PH_MEM_WB, PH_BRANCH,
    PH_JUMP, PH_HALT
  } phase_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, flags_write, illegal, halted;

  outv_t  act;
  outv_t  exp_q[$];
  phase_e tag_q[$];
  int     errors = 0;
  int     checks = 0;

  assign act = {alu_ctrl, alu_src_a, alu_src_b, pc_source, pc_write,
                pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                reg_write, reg_dst, mem_to_reg, flags_write, illegal, halted};

  mc_main_control #(.OP_W(6), .FN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .flags_write(flags_write),
    .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  // R-type function table: {known, alu code}
  function automatic logic [4:0] fn_lookup(input logic [5:0] fn);
    case (fn)
      6'b100100: return {1'b1, 4'b0001};
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b0011};
      6'b101010: return {1'b1, 4'b0100};
      6'b000000: return {1'b1, 4'b1100};
      6'b000010: return {1'b1, 4'b1101};
      6'b000100: return {1'b1, 4'b1110};
      6'b000110: return {1'b1, 4'b1111};
      default:   return 5'b0;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b001100, 6'b100011,
                      6'b101011, 6'b000100, 6'b000010, 6'b111111};
  endfunction

  // Expected outputs for one cycle spent in a given phase.
  function automatic outv_t expect_out(input phase_e ph, input logic mr,
                                       input logic [5:0] op, input logic [5:0] fn);
    outv_t      e;
    logic [4:0] f;
    e = '0;
    f = fn_lookup(fn);
    case (ph)
      PH_FETCH: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010;
        e.ir_write = mr;   e.pc_write = mr;
      end
      PH_DECODE: begin
        e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; e.illegal = !op_known(op);
      end
      PH_EXEC_R: begin
        e.alu_src_a = 1'b1;
        if (f[4]) begin
          e.alu_ctrl    = f[3:0];
          e.flags_write = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b101010);
        end else begin
          e.illegal = 1'b1;
        end
      end
      PH_EXEC_I: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_ctrl = (op == 6'b001000) ? 4'b0010 : 4'b0001;
        e.flags_write = (op == 6'b001000);
      end
      PH_WB_R:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      PH_WB_I:  e.reg_write = 1'b1;
      PH_MEM_ADDR: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010;
      end
      PH_MEM_RD: begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
      PH_MEM_WR: begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      PH_MEM_WB: begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      PH_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0101; e.pc_source = 2'b01;
        e.pc_write_cond = 1'b1;
      end
      PH_JUMP: begin e.pc_source = 2'b10; e.pc_write = 1'b1; end
      PH_HALT: e.halted = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle in phase ph with mem_ready = mr.
  task automatic step(input phase_e ph, input logic mr);
    mem_ready = mr;
    exp_q.push_back(expect_out(ph, mr, opcode, funct));
    tag_q.push_back(ph);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_phase(input int fstall);
    repeat (fstall) step(PH_FETCH, 1'b0);
    step(PH_FETCH, 1'b1);
  endtask

  // Walk one instruction through the phases its opcode/funct implies.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fstall, input int mstall);
    logic [4:0] f;
    opcode = op;
    funct  = fn;
    f = fn_lookup(fn);
    fetch_phase(fstall);
    step(PH_DECODE, rbit());
    case (op)
      6'b000000: begin
        step(PH_EXEC_R, rbit());
        if (f[4] && fn != 6'b101010) step(PH_WB_R, rbit());
      end
      6'b001000, 6'b001100: begin
        step(PH_EXEC_I, rbit());
        step(PH_WB_I, rbit());
      end
      6'b100011: begin
        step(PH_MEM_ADDR, rbit());
        repeat (mstall) step(PH_MEM_RD, 1'b0);
        step(PH_MEM_RD, 1'b1);
        step(PH_MEM_WB, rbit());
      end
      6'b101011: begin
        step(PH_MEM_ADDR, rbit());
        repeat (mstall) step(PH_MEM_WR, 1'b0);
        step(PH_MEM_WR, 1'b1);
      end
      6'b000100: step(PH_BRANCH, rbit());
      6'b000010: step(PH_JUMP, rbit());
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(PH_RESET, rbit());
    step(PH_RESET, rbit());
    rst_n = 1'b1;
    step(PH_INIT, 1'b1);
  endtask

  // Monitor: compare every cycle against the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      outv_t  e;
      phase_e p;
      e = exp_q.pop_front();
      p = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", p.name(), act, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op, fn;
    int         r;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(PH_RESET, 1'b1);
    rst_n = 1'b1;
    step(PH_INIT, 1'b1);

    // Directed cases
    run_instr(6'b000000, 6'b100010, 0, 0);  // SUB
    run_instr(6'b100011, 6'b000000, 2, 3);  // LW with MEM_RD stalls
    run_instr(6'b000100, 6'b000000, 0, 0);  // BEQ
    run_instr(6'b000010, 6'b000000, 1, 0);  // J
    run_instr(6'b010101, 6'b000000, 0, 0);  // illegal opcode
    run_instr(6'b000000, 6'b111111, 0, 0);  // illegal funct
    run_instr(6'b000000, 6'b101010, 0, 0);  // CMP, no writeback
    run_instr(6'b001000, 6'b000000, 0, 0);  // ADDI
    run_instr(6'b001100, 6'b000000, 0, 0);  // ANDI
    run_instr(6'b101011, 6'b000000, 0, 2);  // SW with stalls

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 9: op = 6'b000000;
        2: op = 6'b001000;
        3: op = 6'b001100;
        4: op = 6'b100011;
        5: op = 6'b101011;
        6: op = 6'b000100;
        7: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op_known(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 7))
          0: fn = 6'b100100;
          1: fn = 6'b100000;
          2: fn = 6'b100010;
          3: fn = 6'b101010;
          4: fn = 6'b000000;
          5: fn = 6'b000010;
          6: fn = 6'b000100;
          default: fn = 6'b000110;
        endcase
      end else begin
        fn = 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a store
    opcode = 6'b101011;
    funct  = 6'b000000;
    fetch_phase(0);
    step(PH_DECODE, rbit());
    step(PH_MEM_ADDR, rbit());
    mem_ready = 1'b0;
    exp_q.push_back(expect_out(PH_MEM_WR, 1'b0, opcode, funct));
    tag_q.push_back(PH_MEM_WR);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== outv_t'('0)) begin
      errors++;
      $display("FAIL async_abort: got %h expected %h", act, outv_t'('0));
    end
    @(posedge clk);
    #1;
    step(PH_RESET, 1'b1);
    rst_n = 1'b1;
    step(PH_INIT, 1'b1);
    run_instr(6'b001000, 6'b000000, 0, 0);

    // HALT holds regardless of mem_ready
    run_instr(6'b111111, 6'b000000, 0, 0);
    repeat (20) step(PH_HALT, rbit());

    // Reset recovers from HALT
    do_reset();
    run_instr(6'b000000, 6'b100000, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
